// File: rtl/cpu_controller_param_if.sv
// Control bundle between an instruction sequencer (master) and the
// cpu_controller_param FSM (slave): launch/step inputs and datapath strobes.
interface cpu_controller_param_if #(
  parameter int NREG = 8,
  parameter int IW   = 23
);
  logic            start;
  logic            run;
  logic [IW-1:0]   inst;
  logic            zero;
  logic [NREG-1:0] r_en_oh;
  logic [NREG+1:0] tri_oh;
  logic            ir_en;
  logic            a_en;
  logic            g_en;
  logic            inc_pc;
  logic            branch;
  logic [1:0]      alu_op;
  logic            busy;
  logic            done;

  modport master (
    output start, run, inst, zero,
    input  r_en_oh, tri_oh, ir_en, a_en, g_en, inc_pc, branch, alu_op, busy, done
  );

  modport slave (
    input  start, run, inst, zero,
    output r_en_oh, tri_oh, ir_en, a_en, g_en, inc_pc, branch, alu_op, busy, done
  );
endinterface

// File: rtl/cpu_controller_param.sv
// Multi-cycle control FSM for a simple bus-based CPU datapath: fetch, decode
// and up to three execute cycles, with all strobes decoded from state and inst.
module cpu_controller_param #(
  parameter int NREG = 8,
  parameter int OPW  = 3,
  parameter int IW   = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_controller_param_if.slave bus
);
  localparam int RW = $clog2(NREG);
  localparam int TW = NREG + 2;

  localparam logic [OPW-1:0] OP_MV   = OPW'(0);
  localparam logic [OPW-1:0] OP_MVI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4);
  localparam logic [OPW-1:0] OP_BEQZ = OPW'(5);
  localparam logic [OPW-1:0] OP_HALT = OPW'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EX1,
    S_EX2,
    S_EX3,
    S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [OPW-1:0]  op;
  logic [RW-1:0]   rx;
  logic [RW-1:0]   ry;
  logic            reg_ok;
  logic            unused_inst_bits;

  logic [NREG-1:0] r_en_oh;
  logic [TW-1:0]   tri_oh;
  logic            ir_en;
  logic            a_en;
  logic            g_en;
  logic            inc_pc;
  logic            branch;
  logic [1:0]      alu_op;
  logic            done;
  logic            to_halt;

  assign op = bus.inst[IW-1 -: OPW];
  assign rx = bus.inst[IW-1-OPW -: RW];
  assign ry = bus.inst[IW-1-OPW-RW -: RW];

  // Low instruction bits below the ry field carry no control information.
  assign unused_inst_bits = ^bus.inst;

  // Register fields that decode past the last register (non-power-of-2 NREG)
  // demote the whole instruction to a NOP.
  assign reg_ok = (32'(rx) < 32'(NREG)) && (32'(ry) < 32'(NREG));

  // NOTE: sequential state uses <= so every flop samples pre-edge values; rst
  // sits in the sensitivity list so it forces IDLE without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    r_en_oh = '0;
    tri_oh  = '0;
    ir_en   = 1'b0;
    a_en    = 1'b0;
    g_en    = 1'b0;
    inc_pc  = 1'b0;
    branch  = 1'b0;
    alu_op  = 2'b00;
    done    = 1'b0;
    to_halt = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_en   = 1'b1;
        inc_pc  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!reg_ok) begin
          done = 1'b1;
        end else begin
          case (op)
            OP_MV: begin
              tri_oh  = TW'(1) << ry;
              r_en_oh = NREG'(1) << rx;
              done    = 1'b1;
            end
            OP_MVI: begin
              tri_oh  = TW'(1) << (NREG + 1);
              r_en_oh = NREG'(1) << rx;
              done    = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              state_d = S_EX1;
            end
            OP_BEQZ: begin
              branch = bus.zero;
              done   = 1'b1;
            end
            OP_HALT: begin
              done    = 1'b1;
              to_halt = 1'b1;
            end
            default: begin
              done = 1'b1;
            end
          endcase
        end
      end
      S_EX1: begin
        tri_oh  = TW'(1) << rx;
        a_en    = 1'b1;
        state_d = S_EX2;
      end
      S_EX2: begin
        tri_oh  = TW'(1) << ry;
        g_en    = 1'b1;
        alu_op  = 2'(op - OP_ADD);
        state_d = S_EX3;
      end
      S_EX3: begin
        tri_oh  = TW'(1) << NREG;
        r_en_oh = NREG'(1) << rx;
        done    = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (done) begin
      if (to_halt)      state_d = S_HALT;
      else if (bus.run) state_d = S_FETCH;
      else              state_d = S_IDLE;
    end
  end

  assign bus.r_en_oh = r_en_oh;
  assign bus.tri_oh  = tri_oh;
  assign bus.ir_en   = ir_en;
  assign bus.a_en    = a_en;
  assign bus.g_en    = g_en;
  assign bus.inc_pc  = inc_pc;
  assign bus.branch  = branch;
  assign bus.alu_op  = alu_op;
  assign bus.done    = done;
  assign bus.busy    = (state_q != S_IDLE) && (state_q != S_HALT);
endmodule

// File: tb/tb_cpu_controller_param.sv
// Bench for cpu_controller_param: directed scenarios on NREG=8 and NREG=6
// instances, then a randomized program soak checked through a scoreboard.
module tb_cpu_controller_param;
  typedef struct packed {
    logic [15:0] ren;
    logic [17:0] tsel;
    logic        ir_en;
    logic        a_en;
    logic        g_en;
    logic        inc_pc;
    logic        branch;
    logic [1:0]  alu_op;
    logic        busy;
    logic        done;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        run;
  logic        zero;
  logic [22:0] inst;
  logic        use6;
  logic        mon_on;
  logic        sb_on;
  int          checks;
  int          failures;
  obs_t        exp_q[$];

  cpu_controller_param_if #(.NREG(8), .IW(23)) bus8 ();
  cpu_controller_param_if #(.NREG(6), .IW(23)) bus6 ();

  cpu_controller_param #(.NREG(8), .OPW(3), .IW(23)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );
  cpu_controller_param #(.NREG(6), .OPW(3), .IW(23)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6)
  );

  assign bus8.start = start & ~use6;
  assign bus6.start = start & use6;
  assign bus8.run   = run;
  assign bus6.run   = run;
  assign bus8.inst  = inst;
  assign bus6.inst  = inst;
  assign bus8.zero  = zero;
  assign bus6.zero  = zero;

  function automatic obs_t mk(input logic [15:0] ren, input logic [17:0] tsel,
                              input logic ir, input logic a, input logic g,
                              input logic inc, input logic br, input logic [1:0] alu,
                              input logic busy, input logic done);
    obs_t o;
    o.ren = ren; o.tsel = tsel; o.ir_en = ir; o.a_en = a; o.g_en = g;
    o.inc_pc = inc; o.branch = br; o.alu_op = alu; o.busy = busy; o.done = done;
    return o;
  endfunction

  obs_t obs8, obs6, obs;
  assign obs8 = mk(16'(bus8.r_en_oh), 18'(bus8.tri_oh), bus8.ir_en, bus8.a_en, bus8.g_en,
                   bus8.inc_pc, bus8.branch, bus8.alu_op, bus8.busy, bus8.done);
  assign obs6 = mk(16'(bus6.r_en_oh), 18'(bus6.tri_oh), bus6.ir_en, bus6.a_en, bus6.g_en,
                   bus6.inc_pc, bus6.branch, bus6.alu_op, bus6.busy, bus6.done);
  assign obs  = use6 ? obs6 : obs8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input int op, input int rx, input int ry);
    inst        = 23'($urandom);
    inst[22:20] = 3'(op);
    inst[19:17] = 3'(rx);
    inst[16:14] = 3'(ry);
  endtask

  function automatic obs_t fetch_exp();
    return mk(16'h0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
  endfunction

  // Reference model: per-cycle output table for one instruction, from the
  // instruction-set description (FETCH row followed by its decode/execute rows).
  function automatic bit is_alu(input int op, input int rx, input int ry, input int nreg);
    return (op >= 2) && (op <= 4) && (rx < nreg) && (ry < nreg);
  endfunction

  function automatic int latency(input int op, input int rx, input int ry, input int nreg);
    return is_alu(op, rx, ry, nreg) ? 5 : 2;
  endfunction

  function automatic void push_trace(input int op, input int rx, input int ry,
                                     input bit z, input int nreg);
    exp_q.push_back(fetch_exp());
    if (rx >= nreg || ry >= nreg || op >= 6) begin
      exp_q.push_back(mk(16'h0, 18'h0, 0, 0, 0, 0, 0, 2'b00, 1, 1));
    end else if (is_alu(op, rx, ry, nreg)) begin
      exp_q.push_back(mk(16'h0, 18'h0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
      exp_q.push_back(mk(16'h0, 18'(1) << rx, 0, 1, 0, 0, 0, 2'b00, 1, 0));
      exp_q.push_back(mk(16'h0, 18'(1) << ry, 0, 0, 1, 0, 0, 2'(op - 2), 1, 0));
      exp_q.push_back(mk(16'(1) << rx, 18'(1) << nreg, 0, 0, 0, 0, 0, 2'b00, 1, 1));
    end else if (op == 0) begin
      exp_q.push_back(mk(16'(1) << rx, 18'(1) << ry, 0, 0, 0, 0, 0, 2'b00, 1, 1));
    end else if (op == 1) begin
      exp_q.push_back(mk(16'(1) << rx, 18'(1) << (nreg + 1), 0, 0, 0, 0, 0, 2'b00, 1, 1));
    end else begin
      exp_q.push_back(mk(16'h0, 18'h0, 0, 0, 0, 0, z, 2'b00, 1, 1));
    end
  endfunction

  // Monitor: one-hot invariants every cycle; in scoreboard mode each busy
  // cycle consumes one expected row, and non-busy cycles must be all zero.
  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check("onehot_r_en", 64'($countones(obs.ren) <= 1), 64'(1));
        check("onehot_tri", 64'($countones(obs.tsel) <= 1), 64'(1));
      end
      if (sb_on) begin
        if (obs.busy) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_busy", 64'(obs), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("sb_cycle", 64'(obs), 64'(e));
          end
        end else begin
          check("sb_idle", 64'(obs), 64'(0));
        end
      end
    end
  end

  task automatic run_program(input int nreg);
    int n, op, rx, ry, lat;
    bit z, halt, last;
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      op   = $urandom_range(0, 7);
      rx   = $urandom_range(0, 7);
      ry   = $urandom_range(0, 7);
      z    = 1'($urandom_range(0, 1));
      halt = (op == 7) && (rx < nreg) && (ry < nreg);
      last = (i == n - 1) || halt;
      lat  = latency(op, rx, ry, nreg);
      set_inst(op, rx, ry);
      zero = z;
      run  = !last;
      if (i == 0) begin
        start = 1'b1;
        tick();
      end
      // start while busy must be ignored; keep it low on the final instruction
      start = last ? 1'b0 : 1'($urandom_range(0, 1));
      push_trace(op, rx, ry, z, nreg);
      repeat (lat) tick();
      if (halt) begin
        repeat ($urandom_range(1, 4)) begin
          start = 1'($urandom_range(0, 1));
          run   = 1'($urandom_range(0, 1));
          tick();
        end
        start = 1'b0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; run = 1'b0; zero = 1'b0; inst = '0;
    use6 = 1'b0; mon_on = 1'b0; sb_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'(obs), 64'(0));
    rst = 1'b0;
    mon_on = 1'b1;
    tick();
    check("idle_after_reset", 64'(obs), 64'(0));

    // MV r3 <- r5, single step
    set_inst(0, 3, 5); run = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    check("mv_fetch", 64'(obs), 64'(fetch_exp()));
    tick();
    check("mv_decode", 64'(obs), 64'(mk(16'h08, 18'h020, 0, 0, 0, 0, 0, 2'b00, 1, 1)));
    tick();
    check("mv_idle", 64'(obs), 64'(0));

    // SUB r1 <- r1 - r2
    set_inst(3, 1, 2); start = 1'b1;
    tick(); start = 1'b0;
    check("sub_fetch", 64'(obs), 64'(fetch_exp()));
    tick();
    check("sub_decode", 64'(obs), 64'(mk(16'h0, 18'h0, 0, 0, 0, 0, 0, 2'b00, 1, 0)));
    tick();
    check("sub_ex1", 64'(obs), 64'(mk(16'h0, 18'h002, 0, 1, 0, 0, 0, 2'b00, 1, 0)));
    tick();
    check("sub_ex2", 64'(obs), 64'(mk(16'h0, 18'h004, 0, 0, 1, 0, 0, 2'b01, 1, 0)));
    tick();
    check("sub_ex3", 64'(obs), 64'(mk(16'h02, 18'h100, 0, 0, 0, 0, 0, 2'b00, 1, 1)));
    tick();
    check("sub_idle", 64'(obs), 64'(0));

    // Two BEQZ back to back with run=1
    set_inst(5, 0, 0); zero = 1'b1; run = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("beqz1_fetch", 64'(obs), 64'(fetch_exp()));
    tick();
    check("beqz1_decode", 64'(obs), 64'(mk(16'h0, 18'h0, 0, 0, 0, 0, 1, 2'b00, 1, 1)));
    tick();
    check("beqz2_fetch", 64'(obs), 64'(fetch_exp()));
    set_inst(5, 0, 0); zero = 1'b0; run = 1'b0;
    tick();
    check("beqz2_decode", 64'(obs), 64'(mk(16'h0, 18'h0, 0, 0, 0, 0, 0, 2'b00, 1, 1)));
    tick();
    check("beqz_idle", 64'(obs), 64'(0));

    // HALT holds against start/run until reset
    set_inst(7, 0, 0); start = 1'b1;
    tick(); start = 1'b0;
    check("halt_fetch", 64'(obs), 64'(fetch_exp()));
    tick();
    check("halt_decode", 64'(obs), 64'(mk(16'h0, 18'h0, 0, 0, 0, 0, 0, 2'b00, 1, 1)));
    start = 1'b1; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_hold", 64'(obs), 64'(0));
    end
    start = 1'b0; run = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    set_inst(6, 0, 0); start = 1'b1;
    tick(); start = 1'b0;
    check("fetch_after_halt_reset", 64'(obs), 64'(fetch_exp()));
    tick();
    check("nop_decode", 64'(obs), 64'(mk(16'h0, 18'h0, 0, 0, 0, 0, 0, 2'b00, 1, 1)));
    tick();

    // Asynchronous reset in the middle of EX2 of an AND
    set_inst(4, 4, 6); start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    check("and_ex2", 64'(obs), 64'(mk(16'h0, 18'h040, 0, 0, 1, 0, 0, 2'b10, 1, 0)));
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", 64'(obs), 64'(0));
    #2 rst = 1'b0;
    tick();
    check("idle_after_async_rst", 64'(obs), 64'(0));
    set_inst(6, 0, 0); start = 1'b1;
    tick(); start = 1'b0;
    check("fetch_after_async_rst", 64'(obs), 64'(fetch_exp()));
    tick(); tick();

    // NREG=6 instance: out-of-range register, then legal MV and MVI
    use6 = 1'b1;
    set_inst(0, 7, 1); start = 1'b1;
    tick(); start = 1'b0;
    check("n6_fetch", 64'(obs), 64'(fetch_exp()));
    tick();
    check("n6_bad_rx", 64'(obs), 64'(mk(16'h0, 18'h0, 0, 0, 0, 0, 0, 2'b00, 1, 1)));
    tick();
    set_inst(0, 5, 4); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("n6_mv", 64'(obs), 64'(mk(16'h20, 18'h010, 0, 0, 0, 0, 0, 2'b00, 1, 1)));
    tick();
    set_inst(1, 2, 0); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    check("n6_mvi", 64'(obs), 64'(mk(16'h04, 18'h080, 0, 0, 0, 0, 0, 2'b00, 1, 1)));
    tick();

    // Randomized program soak on both instances through the scoreboard
    sb_on = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      use6 = (ph == 1);
      tick();
      repeat (60) run_program(ph == 1 ? 6 : 8);
      repeat (3) tick();
      check("sb_drained", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
    sb_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
